// File: rtl/param_connection_block.sv
// Connection block: pass-through routing tracks plus configurable track-select muxes into the CLB pins.
// Double-buffered scan config: serial shadow chain, length-checked commit into the active config.
module param_connection_block #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int NUM_PINS_A    = 2,
  parameter int NUM_PINS_B    = 2
) (
  input  logic                       scan_clk,
  input  logic                       scan_rst_n,
  input  logic [CHANNEL_WIDTH/2-1:0] a_in,
  input  logic [CHANNEL_WIDTH/2-1:0] b_in,
  output logic [CHANNEL_WIDTH/2-1:0] a_out,
  output logic [CHANNEL_WIDTH/2-1:0] b_out,
  output logic [NUM_PINS_A-1:0]      pin_a,
  output logic [NUM_PINS_B-1:0]      pin_b,
  input  logic                       scan_in,
  input  logic                       scan_en,
  input  logic                       cfg_commit,
  output logic                       scan_out,
  output logic                       cfg_valid,
  output logic                       cfg_err
);

  localparam int HALF     = CHANNEL_WIDTH / 2;
  localparam int SEL_W    = $clog2(CHANNEL_WIDTH);
  localparam int FLD_W    = SEL_W + 1;
  localparam int NUM_PINS = NUM_PINS_A + NUM_PINS_B;
  localparam int CFG_BITS = NUM_PINS * FLD_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CFG_BITS_C = CNT_W'(CFG_BITS);
  localparam logic [SEL_W:0]   CW_L       = (SEL_W + 1)'(CHANNEL_WIDTH);

  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    SHIFT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_err_q, cfg_err_d;

  logic [CHANNEL_WIDTH-1:0] trk;
  logic [NUM_PINS-1:0]      pins;
  logic [FLD_W-1:0]         fld;

  // Tracks interleave directions so a track index's LSB picks the side it came from.
  for (genvar i = 0; i < HALF; i++) begin : g_trk
    assign trk[2*i]   = a_in[i];
    assign trk[2*i+1] = b_in[i];
  end

  assign b_out = a_in;
  assign a_out = b_in;

  always_comb begin
    pins = '0;
    fld  = '0;
    for (int k = 0; k < NUM_PINS; k++) begin
      fld = active_q[k*FLD_W +: FLD_W];
      if (cfg_valid_q && fld[FLD_W-1] && ({1'b0, fld[SEL_W-1:0]} < CW_L)) begin
        pins[k] = trk[fld[SEL_W-1:0]];
      end
    end
  end

  assign pin_a     = pins[NUM_PINS_A-1:0];
  assign pin_b     = pins[NUM_PINS-1:NUM_PINS_A];
  assign scan_out  = shadow_q[CFG_BITS-1];
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    if (scan_en) begin
      // Shift takes priority over a coincident commit.
      shadow_d = {shadow_q[CFG_BITS-2:0], scan_in};
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      state_d  = SHIFT;
    end else if (cfg_commit && (state_q == SHIFT)) begin
      cnt_d = '0;
      if (cnt_q == CFG_BITS_C) begin
        active_d    = shadow_q;
        cfg_valid_d = 1'b1;
        cfg_err_d   = 1'b0;
        state_d     = ACTIVE;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = cfg_valid_q ? ACTIVE : UNCFG;
      end
    end
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      state_q     <= UNCFG;
      shadow_q    <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_param_connection_block.sv
// Directed bench for param_connection_block with a behavioural config model and expected-output scoreboard.
module tb_param_connection_block;

  logic       scan_clk = 1'b0;
  logic       scan_rst_n;
  logic [3:0] a_in, b_in, a_out, b_out;
  logic [1:0] pin_a, pin_b;
  logic       scan_in, scan_en, cfg_commit;
  logic       scan_out, cfg_valid, cfg_err;

  param_connection_block dut (
    .scan_clk   (scan_clk),
    .scan_rst_n (scan_rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .pin_a      (pin_a),
    .pin_b      (pin_b),
    .scan_in    (scan_in),
    .scan_en    (scan_en),
    .cfg_commit (cfg_commit),
    .scan_out   (scan_out),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
  );

  always #5 scan_clk = ~scan_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_shadow, m_active;
  logic [4:0]  m_cnt;
  logic        m_valid, m_err, m_shifting;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow   = '0;
    m_active   = '0;
    m_cnt      = '0;
    m_valid    = 1'b0;
    m_err      = 1'b0;
    m_shifting = 1'b0;
  endtask

  function automatic logic trk_m(input logic [2:0] s);
    return s[0] ? b_in[s[2:1]] : a_in[s[2:1]];
  endfunction

  function automatic logic [14:0] model_out();
    logic [3:0] pins;
    logic [3:0] f;
    pins = '0;
    for (int k = 0; k < 4; k++) begin
      f = m_active[4*k +: 4];
      pins[k] = (m_valid && f[3]) ? trk_m(f[2:0]) : 1'b0;
    end
    return {b_in, a_in, pins[1:0], pins[3:2], m_valid, m_err, m_shadow[15]};
  endfunction

  task automatic check_dut();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {1'b0, a_out, b_out, pin_a, pin_b, cfg_valid, cfg_err, scan_out}, {1'b0, e.val});
    end
  endtask

  task automatic drive_ab(input logic [3:0] a, input logic [3:0] b, input string tag);
    a_in = a;
    b_in = b;
    sb_q.push_back('{tag, model_out()});
    #1;
    check_dut();
  endtask

  task automatic cycle(input logic se, input logic si, input logic cm, input string tag);
    scan_en    = se;
    scan_in    = si;
    cfg_commit = cm;
    @(posedge scan_clk);
    if (se) begin
      m_shadow   = {m_shadow[14:0], si};
      m_cnt      = (m_cnt == 5'd31) ? m_cnt : m_cnt + 5'd1;
      m_shifting = 1'b1;
    end else if (cm && m_shifting) begin
      if (m_cnt == 5'd16) begin
        m_active = m_shadow;
        m_valid  = 1'b1;
        m_err    = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_cnt      = '0;
      m_shifting = 1'b0;
    end
    sb_q.push_back('{tag, model_out()});
    #1;
    check_dut();
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic shift_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0, "shift");
  endtask

  task automatic commit(input string tag);
    cycle(1'b0, 1'b0, 1'b1, tag);
  endtask

  logic [15:0] rb_word;

  initial begin
    scan_rst_n = 1'b0;
    scan_in    = 1'b0;
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
    a_in       = 4'h0;
    b_in       = 4'h0;
    model_reset();

    // Reset state and pass-through.
    #2;
    drive_ab(4'hA, 4'h5, "reset_outputs");
    chk("reset_b_out", {12'd0, b_out}, 16'h000A);
    chk("reset_a_out", {12'd0, a_out}, 16'h0005);
    chk("reset_pins", {12'd0, pin_a, pin_b}, 16'h0000);
    chk("reset_valid_scan", {14'd0, cfg_valid, scan_out}, 16'h0000);
    #9;
    scan_rst_n = 1'b1;

    // Basic load of 0xFD98.
    shift_word(16'hFD98, 16);
    commit("load_commit");
    chk("load_valid", {15'd0, cfg_valid}, 16'h0001);
    drive_ab(4'b0001, 4'b1000, "load_pins");
    chk("load_pin_a", {14'd0, pin_a}, 16'h0001);
    chk("load_pin_b", {14'd0, pin_b}, 16'h0002);

    // Short shift is rejected; active config keeps driving.
    shift_word(16'h1234, 15);
    commit("short_commit");
    chk("short_err", {14'd0, cfg_valid, cfg_err}, 16'h0003);
    chk("short_pins", {12'd0, pin_a, pin_b}, 16'h0006);
    commit("idle_commit_ignored");
    chk("idle_err_kept", {15'd0, cfg_err}, 16'h0001);
    shift_word(16'hECAB, 16);
    chk("pre_commit_pins_old", {12'd0, pin_a, pin_b}, 16'h0006);
    commit("full_commit");
    chk("full_err_clear", {15'd0, cfg_err}, 16'h0000);
    drive_ab(4'b1110, 4'b0010, "new_cfg_pins");
    chk("new_cfg_pin_ab", {12'd0, pin_a, pin_b}, 16'h000F);

    // Toggle tracks while reprogramming; old config must hold.
    shift_word(16'hFD98, 16);
    commit("reload_commit");
    for (int i = 15; i >= 0; i--) begin
      a_in = 4'($urandom_range(0, 15));
      b_in = 4'($urandom_range(0, 15));
      cycle(1'b1, i[0], 1'b0, "shift_toggle");
    end
    drive_ab(4'b0001, 4'b1000, "toggle_before_commit");
    chk("toggle_old_cfg", {12'd0, pin_a, pin_b}, 16'h0006);
    commit("toggle_commit");

    // Readback of the previously loaded word.
    shift_word(16'hFD98, 16);
    commit("rb_load_commit");
    rb_word = 16'hFD98;
    for (int i = 15; i >= 0; i--) begin
      chk("readback_bit", {15'd0, scan_out}, {15'd0, rb_word[i]});
      cycle(1'b1, 1'b0, 1'b0, "readback_shift");
    end
    commit("rb_zero_commit");
    drive_ab(4'hF, 4'hF, "zero_cfg_pins");
    chk("zero_cfg_pins_const", {12'd0, pin_a, pin_b}, 16'h0000);

    // Reset during a shift.
    shift_word(16'hFFFF, 7);
    #2;
    scan_rst_n = 1'b0;
    model_reset();
    drive_ab(4'h3, 4'hC, "midshift_reset");
    chk("midshift_state", {12'd0, cfg_valid, cfg_err, scan_out, |{pin_a, pin_b}}, 16'h0000);
    chk("midshift_passthru", {8'd0, a_out, b_out}, 16'h00C3);
    @(negedge scan_clk);
    scan_rst_n = 1'b1;
    commit("noshift_commit");
    chk("noshift_no_err", {14'd0, cfg_valid, cfg_err}, 16'h0000);

    chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
